jtag_scan_ctrl: RTL and testbench

JTAG_SCAN_CTRL -- requirements
Module: jtag_scan_ctrl

---
 rtl/jtag_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_jtag_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_ctrl.sv
// JTAG scan controller: walks the TAP from Run-Test/Idle through a DR or IR scan,
// or through a TMS-only TAP reset, and returns the captured TDO bits as one response.
module jtag_scan_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        jtag_TCK,
  output logic        jtag_TMS,
  output logic        jtag_TDI,
  output logic        jtag_TRSTn,
  input  logic        jtag_TDO_data,
  input  logic        jtag_TDO_driven,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RESP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, nxt_state;
  logic [1:0]  op_q;
  logic [5:0]  len_q;
  logic [31:0] data_q;
  logic [7:0]  div_cnt;
  logic [5:0]  idx;
  logic [5:0]  pre_len, total, nidx, k_nxt;
  logic [4:0]  k_cur;
  logic        is_rst, nxt_tms, nxt_tdi;

  // Op 11 is handled exactly like op 10 (TAP reset).
  assign is_rst = op_q[1];

  // Pin values for the TCK bit that follows the current one (index idx+1).
  always_comb begin
    pre_len   = is_rst ? 6'd6 : (op_q[0] ? 6'd4 : 6'd3);
    total     = is_rst ? 6'd6 : pre_len + len_q + 6'd2;
    nidx      = idx + 6'd1;
    k_cur     = idx[4:0] - pre_len[4:0];
    k_nxt     = nidx - pre_len;
    nxt_state = POST;
    nxt_tms   = 1'b0;
    nxt_tdi   = 1'b0;
    if (is_rst) begin
      nxt_state = PRE;
      nxt_tms   = (nidx < 6'd5);
    end else if (nidx < pre_len) begin
      nxt_state = PRE;
      nxt_tms   = op_q[0] && (nidx < 6'd2);
    end else if (k_nxt < len_q) begin
      nxt_state = SHIFT;
      nxt_tms   = (k_nxt == len_q - 6'd1);
      nxt_tdi   = data_q[k_nxt[4:0]];
    end else begin
      nxt_tms   = (k_nxt == len_q);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      op_q       <= '0;
      len_q      <= '0;
      data_q     <= '0;
      div_cnt    <= '0;
      idx        <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      jtag_TCK   <= 1'b0;
      jtag_TMS   <= 1'b0;
      jtag_TDI   <= 1'b0;
      jtag_TRSTn <= 1'b0;
    end else begin
      jtag_TRSTn <= 1'b1;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            len_q     <= {cmd_len == 5'd0, cmd_len};
            data_q    <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= PRE;
            idx       <= '0;
            div_cnt   <= '0;
            rsp_data  <= '0;
            jtag_TCK  <= 1'b0;
            jtag_TMS  <= 1'b1;
            jtag_TDI  <= 1'b0;
          end
        end
        PRE, SHIFT, POST: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!jtag_TCK) begin
              jtag_TCK <= 1'b1;
              if (state == SHIFT)
                rsp_data[k_cur] <= jtag_TDO_driven & jtag_TDO_data;
            end else begin
              // End of a high phase: either start the next bit's low phase or finish.
              jtag_TCK <= 1'b0;
              if (idx == total - 6'd1) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                jtag_TMS  <= 1'b0;
                jtag_TDI  <= 1'b0;
              end else begin
                idx      <= nidx;
                state    <= nxt_state;
                jtag_TMS <= nxt_tms;
                jtag_TDI <= nxt_tdi;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Bench for jtag_scan_ctrl: command table with expected responses, pin-level TMS/TDI
// scoreboard, response latency check, and an abort-by-reset sequence.
module tb_jtag_scan_ctrl;

  localparam int DIV = 3;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic        jtag_TDO_data, jtag_TDO_driven;
  logic        busy;

  int tdo_mode = 0;  // 0 loopback of TDI, 1 constant 1, 2 undriven
  assign jtag_TDO_driven = (tdo_mode != 2);
  assign jtag_TDO_data   = (tdo_mode == 0) ? jtag_TDI : 1'b1;

  jtag_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .clock(clock), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  len;
    logic [31:0] data;
    int          mode;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  typedef struct { logic tms; logic tdi; } bit_t;
  typedef struct { logic [31:0] data; int start; int n; } rsp_t;

  bit_t bq[$];
  rsp_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ntck = 0;
  bit   mon_en = 1'b1;
  logic tck_q = 1'b0;
  logic rv_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected pin sequence built from the TAP state walk for each op.
  task automatic push_bits(input logic [1:0] op, input logic [4:0] len,
                           input logic [31:0] data, output int n);
    int l;
    l = (len == 5'd0) ? 32 : int'(len);
    if (op[1]) begin
      for (int i = 0; i < 5; i++) bq.push_back('{1'b1, 1'b0});
      bq.push_back('{1'b0, 1'b0});
      n = 6;
    end else begin
      bq.push_back('{1'b1, 1'b0});
      if (op == 2'b01) bq.push_back('{1'b1, 1'b0});
      bq.push_back('{1'b0, 1'b0});
      bq.push_back('{1'b0, 1'b0});
      for (int k = 0; k < l; k++) bq.push_back('{k == l - 1, data[k]});
      bq.push_back('{1'b1, 1'b0});
      bq.push_back('{1'b0, 1'b0});
      n = l + ((op == 2'b01) ? 6 : 5);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    bit_t b;
    rsp_t r;
    #1;
    if (mon_en) begin
      if (jtag_TCK && !tck_q) begin
        ntck++;
        if (bq.size() == 0) chk("tck_extra", 32'(bq.size()), 1);
        else begin
          b = bq.pop_front();
          chk("tms", 32'(jtag_TMS), 32'(b.tms));
          chk("tdi", 32'(jtag_TDI), 32'(b.tdi));
        end
      end
      if (rsp_valid && !rv_q) begin
        if (rq.size() == 0) chk("rsp_extra", 32'(rq.size()), 1);
        else begin
          r = rq.pop_front();
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_latency", 32'(cyc - r.start), 32'(r.n * 2 * DIV));
          chk("tck_count", 32'(bq.size()), 0);
          chk("pins_in_resp", {29'd0, jtag_TCK, jtag_TMS, jtag_TDI}, 0);
        end
      end
    end
    tck_q = jtag_TCK;
    rv_q  = rsp_valid;
  end

  task automatic issue(input vec_t v, output bit ok);
    int n;
    bit rdy;
    tdo_mode  = v.mode;
    cmd_op    = v.op;
    cmd_len   = v.len;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = cmd_ready;
      @(posedge clock); #1;
      ok = rdy;
    end
    chk("cmd_accept", 32'(ok), 1);
    if (ok) begin
      push_bits(v.op, v.len, v.data, n);
      rq.push_back('{v.exp, cyc, n});
    end
    // Keep a different request pending while busy; it must not disturb the scan.
    cmd_op   = 2'b10;
    cmd_len  = 5'd3;
    cmd_data = 32'hFFFF_0000;
  endtask

  task automatic run_cmd(input vec_t v);
    bit ok, got;
    issue(v, ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    chk("busy_on_accept", 32'(busy), 1);
    chk("ready_low_busy", 32'(cmd_ready), 0);
    if (v.hold == 0) rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 * DIV && !got; i++) begin
      @(posedge clock); #1;
      got = rsp_valid;
    end
    cmd_valid = 1'b0;
    chk("rsp_arrives", 32'(got), 1);
    if (!got) begin
      rsp_ready = 1'b0;
      return;
    end
    chk("ready_low_resp", 32'(cmd_ready), 0);
    for (int i = 0; i < v.hold; i++) begin
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", rsp_data, v.exp);
      chk("hold_ready", 32'(cmd_ready), 0);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("ready_back", 32'(cmd_ready), 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {25'd0, cmd_ready, rsp_valid, busy, jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}, 0);
    chk("rst_rsp_data", rsp_data, 0);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t abort_v;
    bit ok, seen;
    int base;

    vecs[0] = '{2'b00, 5'd8,  32'h0000_00A5, 0, 3,  32'h0000_00A5};
    vecs[1] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 1, 0,  32'hFFFF_FFFF};
    vecs[2] = '{2'b00, 5'd4,  32'h0000_000D, 2, 1,  32'h0000_0000};
    vecs[3] = '{2'b10, 5'd9,  32'hFFFF_FFFF, 1, 10, 32'h0000_0000};
    vecs[4] = '{2'b11, 5'd7,  32'h0000_00FF, 0, 0,  32'h0000_0000};
    vecs[5] = '{2'b00, 5'd1,  32'h0000_0001, 0, 2,  32'h0000_0001};
    vecs[6] = '{2'b01, 5'd5,  32'h0000_0013, 0, 0,  32'h0000_0013};
    vecs[7] = '{2'b00, 5'd0,  32'h1234_5678, 0, 1,  32'h1234_5678};
    vecs[8] = '{2'b00, 5'd31, 32'hFFFF_FFFF, 0, 0,  32'h7FFF_FFFF};
    vecs[9] = '{2'b01, 5'd3,  32'h0000_00FF, 1, 2,  32'h0000_0007};

    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("reset_outputs");
    rstn = 1'b1;
    @(posedge clock); #1;
    chk("trstn_after_reset", 32'(jtag_TRSTn), 1);
    chk("ready_after_reset", 32'(cmd_ready), 1);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // Abort during SHIFT bit 3 of a DR scan (7th TCK rise).
    abort_v = '{2'b00, 5'd8, 32'h0000_005A, 0, 0, 32'h0000_005A};
    base = ntck;
    issue(abort_v, ok);
    for (int i = 0; i < 200 && ntck < base + 7; i++) begin
      @(posedge clock); #1;
    end
    chk("abort_reached_shift", 32'(ntck - base), 7);
    mon_en = 1'b0;
    #2 rstn = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk_reset_vals("abort_outputs");
    bq.delete();
    rq.delete();
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("abort_held");
    rstn = 1'b1;
    @(posedge clock); #1;
    chk("abort_trstn", 32'(jtag_TRSTn), 1);
    chk("abort_ready", 32'(cmd_ready), 1);
    mon_en = 1'b1;
    seen = 1'b0;
    repeat (120) begin
      @(posedge clock); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_abort", 32'(seen), 0);
    run_cmd(vecs[0]);
    run_cmd(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
